// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving one external 2-port BRAM.
// The BRAM read register doubles as the head-of-queue slot, giving DEPTH+1 words of capacity.
module bram_fifo_ctrl #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DEPTH         = 2**ADDR_WIDTH,
   parameter int BYTE_WIDTH    = 9,
   parameter int NUM_BYTES     = 4,
   parameter int AFULL_THRESH  = 240,
   parameter int AEMPTY_THRESH = 16,
   localparam int W            = BYTE_WIDTH*NUM_BYTES
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  push_i,
   input  logic [W-1:0]          wr_data_i,
   input  logic [NUM_BYTES-1:0]  wr_be_i,
   output logic                  full_o,
   output logic                  afull_o,
   input  logic                  pop_i,
   output logic [W-1:0]          rd_data_o,
   output logic                  rd_valid_o,
   output logic                  aempty_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   output logic                  ram_wen_no,
   output logic [W-1:0]          ram_bwen_no,
   output logic [ADDR_WIDTH-1:0] ram_waddr_o,
   output logic [W-1:0]          ram_data_o,
   output logic                  ram_ren_no,
   output logic [ADDR_WIDTH-1:0] ram_raddr_o,
   input  logic [W-1:0]          ram_q_i
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
   logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_acc, rd_iss;
   logic [ADDR_WIDTH:0]   count;

   // flags come only from registered state
   assign full_o      = (ram_cnt_q == DEPTH_C);
   assign count       = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, rd_valid_q};
   assign count_o     = count;
   assign afull_o     = (count >= AFULL_C);
   assign aempty_o    = (count <= AEMPTY_C);
   assign rd_valid_o  = rd_valid_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;

   assign wr_acc = push_i & ~full_o & ~clr_i;
   assign rd_iss = (ram_cnt_q != '0) & (~rd_valid_q | pop_i) & ~clr_i;

   assign ram_wen_no  = ~wr_acc;
   assign ram_waddr_o = wptr_q;
   assign ram_data_o  = wr_data_i;
   assign ram_ren_no  = ~rd_iss;
   assign ram_raddr_o = rptr_q;

   // the BRAM holds q while no read is issued, so the head word is read straight through
   assign rd_data_o = ram_q_i;

   always_comb begin
      ram_bwen_no = '1;
      for (int b = 0; b < NUM_BYTES; b++) begin
         ram_bwen_no[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{~wr_be_i[b]}};
      end
   end

   always_comb begin
      ram_cnt_d  = ram_cnt_q;
      rd_valid_d = rd_valid_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      if (clr_i) begin
         ram_cnt_d  = '0;
         rd_valid_d = 1'b0;
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
      end else begin
         case ({wr_acc, rd_iss})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
         endcase
         if (rd_iss) begin
            rd_valid_d = 1'b1;
         end else if (pop_i) begin
            rd_valid_d = 1'b0;
         end
         // a push while full is dropped even if a read frees a slot this cycle
         if (push_i && full_o) begin
            ovf_d = 1'b1;
         end
         if (pop_i && !rd_valid_q) begin
            udf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         ram_cnt_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         ram_cnt_q  <= ram_cnt_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (wr_acc) begin
               wptr_q <= wptr_q + 1'b1;
            end
            if (rd_iss) begin
               rptr_q <= rptr_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: behavioural BRAM plus a queue-based FIFO reference model.
module tb_bram_fifo_ctrl;
   localparam int AW = 8;
   localparam int W  = 36;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clr_i, push_i, pop_i;
   logic [W-1:0]  wr_data_i;
   logic [3:0]    wr_be_i;
   logic          full_o, afull_o, rd_valid_o, aempty_o, overflow_o, underflow_o;
   logic [W-1:0]  rd_data_o;
   logic [AW:0]   count_o;
   logic          ram_wen_no, ram_ren_no;
   logic [W-1:0]  ram_bwen_no, ram_data_o, ram_q_i;
   logic [AW-1:0] ram_waddr_o, ram_raddr_o;

   always #5 clk_i = ~clk_i;

   bram_fifo_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
      .push_i(push_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
      .full_o(full_o), .afull_o(afull_o),
      .pop_i(pop_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .aempty_o(aempty_o), .count_o(count_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o),
      .ram_wen_no(ram_wen_no), .ram_bwen_no(ram_bwen_no),
      .ram_waddr_o(ram_waddr_o), .ram_data_o(ram_data_o),
      .ram_ren_no(ram_ren_no), .ram_raddr_o(ram_raddr_o),
      .ram_q_i(ram_q_i)
   );

   // 256x36 BRAM, bit-level active-low write enables, registered read that holds q when idle
   logic [W-1:0] mem [0:255];
   logic [W-1:0] ram_q;
   assign ram_q_i = ram_q;
   always @(posedge clk_i) begin
      if (!ram_wen_no) mem[ram_waddr_o] <= (mem[ram_waddr_o] & ram_bwen_no) | (ram_data_o & ~ram_bwen_no);
      if (!ram_ren_no) ram_q <= mem[ram_raddr_o];
   end

   // reference: all held words in order; m_hv = head word already sits in the read register
   logic [W-1:0] mq [$];
   bit           m_hv, m_ovf, m_udf;
   int           n_vec, n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_hv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic drive(input bit p, input logic [W-1:0] d, input logic [3:0] be, input bit po, input bit c);
      push_i    = p;
      wr_data_i = d;
      wr_be_i   = be;
      pop_i     = po;
      clr_i     = c;
   endtask

   task automatic tick();
      int  sz, in_ram;
      bit  iss;
      @(negedge clk_i);
      sz = mq.size();
      chk("count", {55'd0, count_o}, 64'(sz));
      chk("rd_valid", {63'd0, rd_valid_o}, {63'd0, m_hv});
      chk("full", {63'd0, full_o}, {63'd0, (sz - int'(m_hv)) == 256});
      chk("afull", {63'd0, afull_o}, {63'd0, sz >= 240});
      chk("aempty", {63'd0, aempty_o}, {63'd0, sz <= 16});
      chk("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
      chk("underflow", {63'd0, underflow_o}, {63'd0, m_udf});
      if (m_hv) chk("rd_data", {28'd0, rd_data_o}, {28'd0, mq[0]});
      @(posedge clk_i);
      in_ram = mq.size() - int'(m_hv);
      if (clr_i) begin
         model_reset();
      end else begin
         iss = (in_ram > 0) && (!m_hv || pop_i);
         if (push_i && in_ram == 256) m_ovf = 1'b1;
         if (pop_i && !m_hv) m_udf = 1'b1;
         if (pop_i && m_hv) void'(mq.pop_front());
         m_hv = iss ? 1'b1 : (pop_i ? 1'b0 : m_hv);
         if (push_i && in_ram != 256) mq.push_back(wr_data_i);
      end
      #1;
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   initial begin
      n_vec  = 0;
      n_err  = 0;
      rst_ni = 1'b0;
      drive(0, '0, 4'hF, 0, 0);
      model_reset();
      #12;
      chk("rst_rd_valid", {63'd0, rd_valid_o}, 64'd0);
      chk("rst_count", {55'd0, count_o}, 64'd0);
      chk("rst_aempty", {63'd0, aempty_o}, 64'd1);
      chk("rst_wen", {63'd0, ram_wen_no}, 64'd1);
      chk("rst_ren", {63'd0, ram_ren_no}, 64'd1);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // single word latency
      drive(1, 36'h123456789, 4'hF, 0, 0);
      #2;
      chk("t2_waddr", {56'd0, ram_waddr_o}, 64'd0);
      chk("t2_bwen", {28'd0, ram_bwen_no}, 64'd0);
      chk("t2_wen", {63'd0, ram_wen_no}, 64'd0);
      tick();
      drive(0, '0, 4'hF, 0, 0);
      #2;
      chk("t2_count1", {55'd0, count_o}, 64'd1);
      chk("t2_ren", {63'd0, ram_ren_no}, 64'd0);
      tick();
      #2;
      chk("t2_valid", {63'd0, rd_valid_o}, 64'd1);
      chk("t2_data", {28'd0, rd_data_o}, 64'h123456789);
      tick();
      drive(0, '0, 4'hF, 1, 0);
      tick();
      drive(0, '0, 4'hF, 0, 0);
      tick();

      // fill to capacity and overflow
      for (int i = 0; i < 258; i++) begin
         drive(1, W'(i), 4'hF, 0, 0);
         tick();
      end
      drive(0, '0, 4'hF, 0, 0);
      #2;
      chk("t3_full", {63'd0, full_o}, 64'd1);
      chk("t3_count", {55'd0, count_o}, 64'd257);
      chk("t3_afull", {63'd0, afull_o}, 64'd1);
      chk("t3_ovf", {63'd0, overflow_o}, 64'd1);
      tick();

      // drain back-to-back across the pointer wrap
      for (int i = 0; i < 257; i++) begin
         drive(0, '0, 4'hF, 1, 0);
         #2;
         chk("t4_valid", {63'd0, rd_valid_o}, 64'd1);
         chk("t4_data", {28'd0, rd_data_o}, 64'(i));
         tick();
      end
      #2;
      chk("t4_empty", {63'd0, rd_valid_o}, 64'd0);
      tick();
      drive(0, '0, 4'hF, 0, 0);
      #2;
      chk("t4_udf", {63'd0, underflow_o}, 64'd1);
      tick();

      drive(0, '0, 4'hF, 0, 1);
      tick();
      drive(0, '0, 4'hF, 0, 0);
      tick();

      // steady state at 10 words with simultaneous push/pop
      for (int i = 0; i < 10; i++) begin
         drive(1, rnd_word(), 4'hF, 0, 0);
         tick();
      end
      for (int i = 0; i < 300; i++) begin
         drive(1, rnd_word(), 4'hF, 1, 0);
         #2;
         chk("t5_count", {55'd0, count_o}, 64'd10);
         tick();
      end
      drive(0, '0, 4'b0001, 0, 0);
      #2;
      chk("t5_bwen", {28'd0, ram_bwen_no}, 64'h0_FFFF_FFE00);
      tick();

      // flush with a competing push
      for (int i = 0; i < 40; i++) begin
         drive(1, rnd_word(), 4'hF, 0, 0);
         tick();
      end
      drive(1, rnd_word(), 4'hF, 0, 1);
      #2;
      chk("t6_count50", {55'd0, count_o}, 64'd50);
      chk("t6_wen", {63'd0, ram_wen_no}, 64'd1);
      chk("t6_ren", {63'd0, ram_ren_no}, 64'd1);
      tick();
      drive(0, '0, 4'hF, 0, 0);
      #2;
      chk("t6_count0", {55'd0, count_o}, 64'd0);
      chk("t6_valid0", {63'd0, rd_valid_o}, 64'd0);
      chk("t6_ovf0", {63'd0, overflow_o}, 64'd0);
      chk("t6_udf0", {63'd0, underflow_o}, 64'd0);
      tick();
      drive(1, 36'hABCDE1234, 4'hF, 0, 0);
      tick();
      drive(0, '0, 4'hF, 0, 0);
      tick();
      #2;
      chk("t6_valid", {63'd0, rd_valid_o}, 64'd1);
      chk("t6_data", {28'd0, rd_data_o}, 64'hABCDE1234);
      tick();

      // randomized traffic: push-heavy, then pop-heavy, with rare flushes and one async reset
      for (int i = 0; i < 3000; i++) begin
         int pp;
         pp = (i < 1500) ? 70 : 30;
         if (i == 2000) begin
            drive(0, '0, 4'hF, 0, 0);
            rst_ni = 1'b0;
            #2;
            chk("ar_count", {55'd0, count_o}, 64'd0);
            chk("ar_valid", {63'd0, rd_valid_o}, 64'd0);
            chk("ar_wen", {63'd0, ram_wen_no}, 64'd1);
            chk("ar_ren", {63'd0, ram_ren_no}, 64'd1);
            model_reset();
            @(posedge clk_i);
            #1 rst_ni = 1'b1;
         end
         drive($urandom_range(99) < pp, rnd_word(), 4'hF,
               $urandom_range(99) < (100 - pp), $urandom_range(199) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
